// File: rtl/sysid_regs.sv
// System identification register block: constant IDs, capability word, scratch,
// a free-running 64-bit uptime counter with coherent hi/lo read, and user ID words.
module sysid_regs #(
  parameter logic [31:0] SYSTEM_ID = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP = 32'h0000_0000,
  parameter int          NUM_USER  = 4,
  parameter logic [7:0]  VERSION   = 8'h02
) (
  input  logic                                           clock,
  input  logic                                           reset,
  input  logic [3:0]                                     address,
  input  logic                                           read,
  input  logic                                           write,
  input  logic [31:0]                                    writedata,
  input  logic [3:0]                                     byteenable,
  input  logic [32*((NUM_USER > 0) ? NUM_USER : 1)-1:0]  user_id,
  output logic [31:0]                                    readdata,
  output logic                                           readdatavalid
);

  localparam logic [3:0] A_SYSID   = 4'd0;
  localparam logic [3:0] A_STAMP   = 4'd1;
  localparam logic [3:0] A_CAPS    = 4'd2;
  localparam logic [3:0] A_SCRATCH = 4'd3;
  localparam logic [3:0] A_UP_LO   = 4'd4;
  localparam logic [3:0] A_UP_HI   = 4'd5;
  localparam logic [3:0] A_CTRL    = 4'd6;

  localparam logic [31:0] CAPS = {16'h0000, VERSION, 4'h0, 4'(NUM_USER)};

  logic [31:0] rdata_q, rdata_d;
  logic        rvld_q;
  logic [31:0] scratch_q, scratch_d;
  logic        run_q, run_d;
  logic [63:0] cnt_q, cnt_d;
  logic [31:0] shadow_q, shadow_d;
  logic        ctrl_wr, clr;
  logic [31:0] user_w [8];
  logic        unused_user;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

  // Words beyond NUM_USER are tied to zero so the read mux never selects outside user_id.
  for (genvar k = 0; k < 8; k++) begin : g_user
    if (k < NUM_USER) begin : g_on
      assign user_w[k] = user_id[32*k +: 32];
    end else begin : g_off
      assign user_w[k] = 32'd0;
    end
  end

  assign unused_user = ^user_id;

  always_comb begin
    rdata_d = 32'd0;
    case (address)
      A_SYSID:   rdata_d = SYSTEM_ID;
      A_STAMP:   rdata_d = TIMESTAMP;
      A_CAPS:    rdata_d = CAPS;
      A_SCRATCH: rdata_d = scratch_q;
      A_UP_LO:   rdata_d = cnt_q[31:0];
      A_UP_HI:   rdata_d = shadow_q;
      A_CTRL:    rdata_d = {31'd0, run_q};
      4'd7:      rdata_d = 32'd0;
      default:   rdata_d = user_w[address[2:0]];
    endcase
  end

  // CLR and RUN both live in byte 0, so they only act when that byte is enabled.
  always_comb begin
    ctrl_wr   = write && (address == A_CTRL) && byteenable[0];
    clr       = ctrl_wr && writedata[1];
    run_d     = ctrl_wr ? writedata[0] : run_q;
    scratch_d = scratch_q;
    if (write && (address == A_SCRATCH)) begin
      scratch_d = merge_bytes(scratch_q, writedata, byteenable);
    end
    if (clr)        cnt_d = 64'd0;
    else if (run_q) cnt_d = cnt_q + 64'd1;
    else            cnt_d = cnt_q;
    shadow_d = (read && (address == A_UP_LO)) ? cnt_q[63:32] : shadow_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rvld_q    <= 1'b0;
      rdata_q   <= 32'd0;
      scratch_q <= 32'd0;
      run_q     <= 1'b1;
      cnt_q     <= 64'd0;
      shadow_q  <= 32'd0;
    end else begin
      rvld_q    <= read;
      rdata_q   <= read ? rdata_d : 32'd0;
      scratch_q <= scratch_d;
      run_q     <= run_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
    end
  end

  assign readdata      = rdata_q;
  assign readdatavalid = rvld_q;

endmodule

// File: tb/tb_sysid_regs.sv
// Bench for sysid_regs: three instances (NUM_USER 4, 2, 0) share stimulus; expected
// read results are queued when a cycle is driven and compared when the response is due.
module tb_sysid_regs;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   address = 4'd0;
  logic         read = 1'b0;
  logic         write = 1'b0;
  logic [31:0]  writedata = 32'd0;
  logic [3:0]   byteenable = 4'd0;
  logic [127:0] uid4 = {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
  logic [31:0]  uid0 = 32'hBAD0_BAD0;
  logic [31:0]  rd4, rd2, rd0;
  logic         v4, v2, v0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        vld;
    logic        any;
    logic [31:0] d4;
    logic [31:0] d2;
    logic [31:0] d0;
  } exp_t;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [3:0]  a;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] e;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[$];

  logic [63:0] cnt_m = 64'd0;
  logic        run_m = 1'b1;
  logic [31:0] shd_m = 32'd0;
  logic [31:0] held;

  sysid_regs #(.SYSTEM_ID(32'h1234_5678), .TIMESTAMP(32'hCAFE_F00D), .NUM_USER(4)) dut4 (
    .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .user_id(uid4),
    .readdata(rd4), .readdatavalid(v4));

  sysid_regs #(.SYSTEM_ID(32'h1234_5678), .TIMESTAMP(32'hCAFE_F00D), .NUM_USER(2)) dut2 (
    .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .user_id(uid4[63:0]),
    .readdata(rd2), .readdatavalid(v2));

  sysid_regs #(.SYSTEM_ID(32'h1234_5678), .TIMESTAMP(32'hCAFE_F00D), .NUM_USER(0)) dut0 (
    .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .user_id(uid0),
    .readdata(rd0), .readdatavalid(v0));

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "time limit");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected value for the NUM_USER=2/0 instances, derived from the dut4 expectation.
  function automatic logic [31:0] fix(input int nu, input logic [3:0] a, input logic [31:0] e4);
    int k;
    if (a == 4'd2) return {16'h0000, 8'h02, 4'h0, nu[3:0]};
    if (a[3]) begin
      k = int'(a[2:0]);
      return (k < nu) ? uid4[32*k +: 32] : 32'd0;
    end
    return e4;
  endfunction

  always @(posedge clock) begin : mon
    exp_t e;
    #1;
    e = '{vld: 1'b0, any: 1'b0, d4: 32'd0, d2: 32'd0, d0: 32'd0};
    if (sbq.size() != 0) e = sbq.pop_front();
    chk("valid4", {31'd0, v4}, {31'd0, e.vld});
    chk("valid2", {31'd0, v2}, {31'd0, e.vld});
    chk("valid0", {31'd0, v0}, {31'd0, e.vld});
    if (!e.any) begin
      chk("rdata4", rd4, e.d4);
      chk("rdata2", rd2, e.d2);
      chk("rdata0", rd0, e.d0);
    end
  end

  task automatic drv(input logic rst, input logic rd, input logic wr, input logic [3:0] a,
                     input logic [31:0] wd, input logic [3:0] be, input logic [31:0] e,
                     input logic anyd);
    exp_t        x;
    logic        clr;
    logic [63:0] nxt;
    @(negedge clock);
    reset = rst; read = rd; write = wr; address = a; writedata = wd; byteenable = be;
    x.vld = rd & ~rst;
    x.any = anyd & x.vld;
    x.d4  = x.vld ? e : 32'd0;
    x.d2  = x.vld ? fix(2, a, e) : 32'd0;
    x.d0  = x.vld ? fix(0, a, e) : 32'd0;
    sbq.push_back(x);
    if (rst) begin
      cnt_m = 64'd0; run_m = 1'b1; shd_m = 32'd0;
    end else begin
      if (rd && a == 4'd4) shd_m = cnt_m[63:32];
      clr = wr && (a == 4'd6) && be[0] && wd[1];
      nxt = clr ? 64'd0 : (run_m ? cnt_m + 64'd1 : cnt_m);
      if (wr && (a == 4'd6) && be[0]) run_m = wd[0];
      cnt_m = nxt;
    end
  endtask

  task automatic rdx(input logic [3:0] a, input logic [31:0] e);
    drv(1'b0, 1'b1, 1'b0, a, 32'd0, 4'd0, e, 1'b0);
  endtask

  task automatic wrx(input logic [3:0] a, input logic [31:0] wd, input logic [3:0] be);
    drv(1'b0, 1'b0, 1'b1, a, wd, be, 32'd0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 32'd0, 1'b0);
  endtask

  initial begin
    tbl.push_back('{1'b1, 1'b0, 4'd0,  32'd0,         4'h0, 32'h1234_5678});
    tbl.push_back('{1'b1, 1'b0, 4'd1,  32'd0,         4'h0, 32'hCAFE_F00D});
    tbl.push_back('{1'b1, 1'b0, 4'd2,  32'd0,         4'h0, 32'h0000_0204});
    tbl.push_back('{1'b1, 1'b0, 4'd3,  32'd0,         4'h0, 32'h0000_0000});
    tbl.push_back('{1'b1, 1'b1, 4'd3,  32'hDEAD_BEEF, 4'h5, 32'h0000_0000});
    tbl.push_back('{1'b1, 1'b0, 4'd3,  32'd0,         4'h0, 32'h00AD_00EF});
    tbl.push_back('{1'b0, 1'b1, 4'd3,  32'h1122_3344, 4'hA, 32'h0000_0000});
    tbl.push_back('{1'b1, 1'b0, 4'd3,  32'd0,         4'h0, 32'h11AD_33EF});
    tbl.push_back('{1'b0, 1'b1, 4'd3,  32'hFFFF_FFFF, 4'h0, 32'h0000_0000});
    tbl.push_back('{1'b1, 1'b0, 4'd3,  32'd0,         4'h0, 32'h11AD_33EF});
    tbl.push_back('{1'b1, 1'b0, 4'd7,  32'd0,         4'h0, 32'h0000_0000});
    tbl.push_back('{1'b0, 1'b1, 4'd0,  32'hFFFF_FFFF, 4'hF, 32'h0000_0000});
    tbl.push_back('{1'b1, 1'b0, 4'd0,  32'd0,         4'h0, 32'h1234_5678});
    tbl.push_back('{1'b0, 1'b1, 4'd2,  32'hFFFF_FFFF, 4'hF, 32'h0000_0000});
    tbl.push_back('{1'b1, 1'b0, 4'd2,  32'd0,         4'h0, 32'h0000_0204});
    tbl.push_back('{1'b0, 1'b1, 4'd7,  32'hFFFF_FFFF, 4'hF, 32'h0000_0000});
    tbl.push_back('{1'b1, 1'b0, 4'd7,  32'd0,         4'h0, 32'h0000_0000});
    tbl.push_back('{1'b1, 1'b0, 4'd8,  32'd0,         4'h0, 32'h1111_0000});
    tbl.push_back('{1'b1, 1'b0, 4'd9,  32'd0,         4'h0, 32'h2222_0001});
    tbl.push_back('{1'b1, 1'b0, 4'd10, 32'd0,         4'h0, 32'h3333_0002});
    tbl.push_back('{1'b1, 1'b0, 4'd11, 32'd0,         4'h0, 32'h4444_0003});
    tbl.push_back('{1'b1, 1'b0, 4'd12, 32'd0,         4'h0, 32'h0000_0000});
    tbl.push_back('{1'b1, 1'b0, 4'd15, 32'd0,         4'h0, 32'h0000_0000});
    tbl.push_back('{1'b1, 1'b0, 4'd6,  32'd0,         4'h0, 32'h0000_0001});
    tbl.push_back('{1'b0, 1'b1, 4'd6,  32'hFFFF_FFFC, 4'hF, 32'h0000_0000});
    tbl.push_back('{1'b1, 1'b0, 4'd6,  32'd0,         4'h0, 32'h0000_0000});
    tbl.push_back('{1'b0, 1'b1, 4'd6,  32'h0000_0001, 4'hE, 32'h0000_0000});
    tbl.push_back('{1'b1, 1'b0, 4'd6,  32'd0,         4'h0, 32'h0000_0000});
    tbl.push_back('{1'b1, 1'b1, 4'd6,  32'h0000_0001, 4'h1, 32'h0000_0000});
    tbl.push_back('{1'b1, 1'b0, 4'd6,  32'd0,         4'h0, 32'h0000_0001});

    // Reset held from time zero; a read during reset must be ignored.
    drv(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 32'd0, 1'b0);
    drv(1'b1, 1'b1, 1'b0, 4'd0, 32'd0, 4'd0, 32'h1234_5678, 1'b0);
    drv(1'b1, 1'b0, 1'b1, 4'd3, 32'hFFFF_FFFF, 4'hF, 32'd0, 1'b0);
    rdx(4'd4, 32'd0);
    rdx(4'd4, 32'd1);
    rdx(4'd5, 32'd0);

    foreach (tbl[i]) drv(1'b0, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].be, tbl[i].e, 1'b0);

    // RUN=0 freezes the counter; RO writes to the uptime words change nothing.
    wrx(4'd6, 32'd0, 4'hF);
    idle(1);
    held = cnt_m[31:0];
    rdx(4'd4, held);
    idle(10);
    wrx(4'd4, 32'h0BAD_0BAD, 4'hF);
    wrx(4'd5, 32'h0BAD_0BAD, 4'hF);
    rdx(4'd4, held);
    wrx(4'd6, 32'h0000_0003, 4'hF);
    rdx(4'd4, 32'd0);
    rdx(4'd4, 32'd1);
    rdx(4'd6, 32'd1);
    rdx(4'd5, 32'd0);

    // Low word at 0xFFFFFFFF: shadow keeps the hi word sampled with it.
    idle(1);
    force dut4.cnt_q = 64'h0000_0000_FFFF_FFFF;
    force dut2.cnt_q = 64'h0000_0000_FFFF_FFFF;
    force dut0.cnt_q = 64'h0000_0000_FFFF_FFFF;
    cnt_m = 64'h0000_0000_FFFF_FFFF;
    rdx(4'd4, 32'hFFFF_FFFF);
    @(posedge clock);
    #2;
    release dut4.cnt_q;
    release dut2.cnt_q;
    release dut0.cnt_q;
    rdx(4'd5, 32'd0);
    drv(1'b0, 1'b1, 1'b0, 4'd4, 32'd0, 4'd0, 32'd0, 1'b1);
    rdx(4'd5, 32'd1);
    wrx(4'd6, 32'h0000_0003, 4'h1);
    rdx(4'd4, 32'd0);

    // user_id is sampled in the read cycle.
    idle(1);
    uid4[63:32] = 32'h5A5A_A5A5;
    rdx(4'd9, 32'h5A5A_A5A5);
    rdx(4'd10, 32'h3333_0002);
    idle(1);

    // Reset coinciding with a read and after a SCRATCH write.
    wrx(4'd3, 32'h5555_AAAA, 4'hF);
    wrx(4'd6, 32'd0, 4'hF);
    rdx(4'd3, 32'h5555_AAAA);
    drv(1'b1, 1'b1, 1'b0, 4'd3, 32'd0, 4'd0, 32'h5555_AAAA, 1'b0);
    rdx(4'd4, 32'd0);
    rdx(4'd4, 32'd1);
    rdx(4'd3, 32'd0);
    rdx(4'd6, 32'd1);
    rdx(4'd5, shd_m);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
